// File: rtl/oled_init_sequencer.sv
// oled_init_sequencer: steps through the 6-entry SSD1306 power-up table and feeds each step to the SPI buffer stage.
// Latency: o_START follows i_GO by 2 cycles. With OLED_RES_PULSE_EN the delay is 2*RES_CYCLES+1 cycles.
// Backpressure: only one step is in flight. The next step waits for a rising edge of i_FINAL_BYTE, with a timeout abort.
// Optional build macro: OLED_RES_PULSE_EN adds a panel reset pulse on o_OLED_RES ahead of step 0.
module oled_init_sequencer #(
  parameter int GAP_CYCLES     = 4,
  parameter int DISP_ON_DELAY  = 100,
  parameter int TIMEOUT_CYCLES = 1024,
`ifdef OLED_RES_PULSE_EN
  parameter int RES_CYCLES     = 16,
`endif
  parameter int CNT_W          = 16
) (
  input  logic        i_SCK,
  input  logic        i_RST,
  input  logic        i_GO,
  input  logic        i_FINAL_BYTE,
  output logic [63:0] o_DATA,
  output logic [7:0]  o_DC,
  output logic [4:0]  o_N_transmit,
  output logic        o_START,
  output logic        o_BUSY,
  output logic        o_DONE,
  output logic        o_ERR,
  output logic [2:0]  o_STEP
`ifdef OLED_RES_PULSE_EN
  ,
  output logic        o_OLED_RES
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_RES_LO, S_RES_HI, S_LOAD, S_START, S_WAIT_TX, S_GAP, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] DISP_LD = CNT_W'(DISP_ON_DELAY);
  // START uses up one cycle of the timeout window.
  // Counting that cycle makes o_ERR rise exactly TIMEOUT_CYCLES after o_START.
  localparam logic [CNT_W-1:0] TMO_LD  = CNT_W'(TIMEOUT_CYCLES - 1);
`ifdef OLED_RES_PULSE_EN
  localparam logic [CNT_W-1:0] RES_LD  = CNT_W'(RES_CYCLES - 1);
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       step_q, step_d;
  logic [63:0]      data_q, data_d;
  logic [7:0]       dc_q, dc_d;
  logic [4:0]       n_q, n_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             fb_prev_q, fb_prev_d;
  logic             fb_rise;
`ifdef OLED_RES_PULSE_EN
  logic             res_q, res_d;
`endif

  // Power-up table: byte 0 sits in the low byte and is shifted out first.
  function automatic logic [63:0] step_data(input logic [2:0] s);
    logic [63:0] v;
    case (s)
      3'd0:    v = 64'h0000_0000_0000_00AE;
      3'd1:    v = 64'h0000_0000_0000_80D5;
      3'd2:    v = 64'h0000_0000_0000_3FA8;
      3'd3:    v = 64'h0000_0000_0000_148D;
      3'd4:    v = 64'h0000_0000_0000_00AF;
      3'd5:    v = 64'hFF00_FF00_FF00_FF00;
      default: v = 64'h0;
    endcase
    return v;
  endfunction

  function automatic logic [4:0] step_len(input logic [2:0] s);
    logic [4:0] v;
    case (s)
      3'd0, 3'd4: v = 5'd1;
      3'd5:       v = 5'd8;
      default:    v = 5'd2;
    endcase
    return v;
  endfunction

  // Step 5 is the only data phase. All other steps are command bytes.
  function automatic logic [7:0] step_dc(input logic [2:0] s);
    return (s == 3'd5) ? 8'hFF : 8'h00;
  endfunction

  // Next-state and next-output logic.
  // Every output is registered, so all of them are computed here.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    data_d    = data_q;
    dc_d      = dc_q;
    n_d       = n_q;
    start_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    fb_prev_d = i_FINAL_BYTE;
`ifdef OLED_RES_PULSE_EN
    res_d     = res_q;
`endif
    // A level that is already high does not complete a transfer. Only a fresh edge does.
    fb_rise   = i_FINAL_BYTE & ~fb_prev_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_GO) begin
          busy_d = 1'b1;
          done_d = 1'b0;
          err_d  = 1'b0;
          step_d = 3'd0;
`ifdef OLED_RES_PULSE_EN
          state_d = S_RES_LO;
          res_d   = 1'b0;
          cnt_d   = RES_LD;
`else
          state_d = S_LOAD;
`endif
        end
      end
`ifdef OLED_RES_PULSE_EN
      S_RES_LO: begin
        if (cnt_q == '0) begin
          state_d = S_RES_HI;
          res_d   = 1'b1;
          cnt_d   = RES_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      // The LOAD cycle counts toward the high time.
      // This keeps the first o_START exactly RES_CYCLES after the reset pin is released.
      S_RES_HI: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
`endif
      S_LOAD: begin
        data_d  = step_data(step_q);
        dc_d    = step_dc(step_q);
        n_d     = step_len(step_q);
        start_d = 1'b1;
        state_d = S_START;
      end
      S_START: begin
        cnt_d   = TMO_LD;
        state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        // When the final-byte edge and the timeout land in the same cycle, the edge takes priority.
        if (fb_rise) begin
          state_d = S_GAP;
          cnt_d   = (step_q == 3'd4) ? DISP_LD : GAP_LD;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          if (step_q == 3'd5) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = S_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and registered outputs.
  // Reset aborts any transfer in progress.
  always_ff @(posedge i_SCK or negedge i_RST) begin
    if (!i_RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      step_q    <= 3'd0;
      data_q    <= 64'h0;
      dc_q      <= 8'h00;
      n_q       <= 5'd0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      fb_prev_q <= 1'b0;
`ifdef OLED_RES_PULSE_EN
      res_q     <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      data_q    <= data_d;
      dc_q      <= dc_d;
      n_q       <= n_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      fb_prev_q <= fb_prev_d;
`ifdef OLED_RES_PULSE_EN
      res_q     <= res_d;
`endif
    end
  end

  assign o_DATA       = data_q;
  assign o_DC         = dc_q;
  assign o_N_transmit = n_q;
  assign o_START      = start_q;
  assign o_BUSY       = busy_q;
  assign o_DONE       = done_q;
  assign o_ERR        = err_q;
  assign o_STEP       = step_q;
`ifdef OLED_RES_PULSE_EN
  assign o_OLED_RES   = res_q;
`endif

endmodule
